adder_sweep_controller: RTL and testbench
=========================================

// Module: adder_sweep_controller
// PURPOSE
//  Self-checking stimulus sequencer for the small ripple-adder datapath (A, B, Cin -> Sum, Cout).
//  On start: drives every {A,B,Cin} combination into the adder under test, holds each vector,
//  compares the DUT result with the golden model, counts mismatches, captures the first failing vector.
//  Replaces waveform-by-eye comparison against golden; sits between the bench and the DUT/golden pair.
// PARAMETERS
//  WIDTH        2  operand width of A and B
//  SETTLE       2  cycles each vector is held before it is checked (>=1)
//  ERRW         8  width of the mismatch counter
//  STOP_ON_FAIL 0  1: end the sweep at the first mismatch; 0: sweep all vectors
// PORTS
//  clk           in   1          single clock; all state changes on posedge
//  reset         in   1          synchronous, active-high
//  start         in   1          start a sweep; sampled only in IDLE or DONE
//  tvA           out  WIDTH      operand A to DUT and golden
//  tvB           out  WIDTH      operand B to DUT and golden
//  tvCin         out  1          carry-in to DUT and golden
//  dutSum        in   WIDTH      DUT sum
//  dutCout       in   1          DUT carry-out
//  goldSum       in   WIDTH      golden sum
//  goldCout      in   1          golden carry-out
//  busy          out  1          high in APPLY/CHECK
//  done          out  1          high while in DONE
//  pass          out  1          done && errCount==0
//  errCount      out  ERRW       mismatch count, saturating
//  firstFailVec  out  2*WIDTH+1  {A,B,Cin} of first mismatch
//  firstFailVld  out  1          firstFailVec holds a capture
// BEHAVIOUR
//  - Clock and reset: one clock, clk; reset is synchronous and active-high.
//  - Reset, including mid-sweep: next edge -> IDLE. All outputs 0. Index, settle count and logger cleared.
//  - Vector index idx: VW = 2*WIDTH+1 bits, N = 2^VW vectors, ascending 0..N-1.
//    tvA = idx[VW-1:WIDTH+1], tvB = idx[WIDTH:1], tvCin = idx[0].
//    Outputs are registered from idx and are 0 outside APPLY/CHECK.
//  - IDLE: start=1 -> APPLY. idx, settle count, errCount and firstFail* are all cleared.
//  - APPLY: hold the vector for SETTLE cycles (settle count 0..SETTLE-1), then -> CHECK.
//  - CHECK (one cycle, vector still driven):
//    - mismatch = {dutCout,dutSum} != {goldCout,goldSum}.
//    - On mismatch: errCount+1, saturating at 2^ERRW-1.
//      If firstFailVld=0: firstFailVec<=idx and firstFailVld<=1.
//    - Next state: idx==N-1, or (STOP_ON_FAIL && mismatch) -> DONE.
//      Otherwise idx+1 and -> APPLY. idx never wraps.
//  - Latency: full sweep takes N*(SETTLE+1) cycles from the start edge to done=1. Default: 32*3 = 96.
//  - DONE: done=1. errCount and firstFail* are held. start=1 restarts exactly as from IDLE.
//  - start while busy: ignored. A level-held start re-triggers only from DONE.
//  - Reset and start in the same cycle: reset wins.
// STRUCTURE
//  - sweep_pkg holds:
//    - state typedef: enum {IDLE, APPLY, CHECK, DONE}
//    - vec_w(WIDTH) function returning 2*WIDTH+1
//    - SETTLE_W localparam helper
//  - One sub-module: sweep_mismatch_logger.
//    Contains the saturating errCount and the first-fail capture.
//    Inputs: clk, reset, clear, check_en, mismatch, idx.
//  - The FSM, settle counter and idx counter stay in the top.
// TESTING
//  1. DUT = golden copy, start pulse:
//     busy for 96 cycles, then done=1, pass=1, errCount=0, firstFailVld=0.
//  2. DUT wrong only at A=10, B=11, Cin=1:
//     errCount=1, firstFailVec=5'b10111, firstFailVld=1, pass=0.
//  3. DUT sum stuck at 00, cout correct:
//     errCount=24, firstFailVec=5'b00001.
//  4. STOP_ON_FAIL=1, DUT fault at idx 23:
//     done at cycle 72, errCount=1, tvA/tvB/tvCin=0 in DONE.
//  5. Reset at cycle 40 of a sweep:
//     next cycle busy=0, tv* outputs=0, errCount=0. A new start then gives a full 96-cycle sweep.
//  6. Start pulses while busy are ignored (done still at cycle 96).
//     start in DONE restarts: errCount clears. ERRW=3 with an always-wrong DUT: errCount=7.

Source files
------------

// File: rtl/adder_sweep_controller_pkg.sv
// Shared types and sizing helpers for the adder sweep controller.
// Sweep state encoding, vector width and settle-counter width.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK,
    DONE
  } sweep_state_e;

  localparam int unsigned SETTLE_W_MIN = 1;

  // {A,B,Cin} packed test-vector width for a given operand width.
  function automatic int unsigned vec_w(input int unsigned width);
    return 2 * width + 1;
  endfunction

  // Settle counter width; SETTLE=1 still needs a 1-bit counter.
  function automatic int unsigned settle_w(input int unsigned settle);
    return (settle > 1) ? $clog2(settle) : SETTLE_W_MIN;
  endfunction

endpackage

// File: rtl/adder_sweep_controller_if.sv
// Test-vector bus between the sweep controller and the DUT/golden adder pair.
// master = controller (drives vectors), slave = adder side (returns results).
interface adder_sweep_controller_if #(
  parameter int unsigned WIDTH = 2
);
  logic [WIDTH-1:0] tvA;
  logic [WIDTH-1:0] tvB;
  logic             tvCin;
  logic [WIDTH-1:0] dutSum;
  logic             dutCout;
  logic [WIDTH-1:0] goldSum;
  logic             goldCout;

  modport master (
    output tvA, tvB, tvCin,
    input  dutSum, dutCout, goldSum, goldCout
  );

  modport slave (
    input  tvA, tvB, tvCin,
    output dutSum, dutCout, goldSum, goldCout
  );
endinterface

// File: rtl/adder_sweep_controller_mismatch_logger.sv
// Saturating mismatch counter plus capture of the first failing {A,B,Cin} vector.
// clear restarts logging at the beginning of each sweep.
module sweep_mismatch_logger #(
  parameter int unsigned VW   = 5,
  parameter int unsigned ERRW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            check_en,
  input  logic            mismatch,
  input  logic [VW-1:0]   idx,
  output logic [ERRW-1:0] err_count,
  output logic [VW-1:0]   first_fail_vec,
  output logic            first_fail_vld
);

  logic [ERRW-1:0] err_q, err_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic            vld_q, vld_d;

  always_comb begin
    err_d = err_q;
    vec_d = vec_q;
    vld_d = vld_q;
    if (clear) begin
      err_d = '0;
      vec_d = '0;
      vld_d = 1'b0;
    end else if (check_en && mismatch) begin
      if (err_q != '1) begin
        err_d = err_q + 1'b1;
      end
      if (!vld_q) begin
        vec_d = idx;
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
      vec_q <= '0;
      vld_q <= 1'b0;
    end else begin
      err_q <= err_d;
      vec_q <= vec_d;
      vld_q <= vld_d;
    end
  end

  assign err_count      = err_q;
  assign first_fail_vec = vec_q;
  assign first_fail_vld = vld_q;

endmodule

// File: rtl/adder_sweep_controller.sv
// Exhaustive {A,B,Cin} sweep sequencer: applies each vector for SETTLE cycles,
// compares DUT against golden for one cycle, and logs mismatches.
module adder_sweep_controller
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH        = 2,
  parameter int unsigned SETTLE       = 2,
  parameter int unsigned ERRW         = 8,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  adder_sweep_controller_if.master  bus,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ERRW-1:0]           errCount,
  output logic [2*WIDTH:0]          firstFailVec,
  output logic                      firstFailVld
);

  localparam int unsigned VW = vec_w(WIDTH);
  localparam int unsigned SW = settle_w(SETTLE);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  sweep_state_e   state_q, state_d;
  logic [VW-1:0]  idx_q, idx_d;
  logic [SW-1:0]  settle_q, settle_d;
  logic [VW-1:0]  tv_q, tv_d;
  logic           clear;
  logic           check_en;
  logic           mismatch;

  assign mismatch = {bus.dutCout, bus.dutSum} != {bus.goldCout, bus.goldSum};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    clear    = 1'b0;
    check_en = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = APPLY;
          idx_d    = '0;
          settle_d = '0;
          clear    = 1'b1;
        end
      end
      APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = CHECK;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      CHECK: begin
        check_en = 1'b1;
        if (idx_q == '1 || (STOP_ON_FAIL && mismatch)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
    // Vector register follows the next state so tv* are zero exactly outside APPLY/CHECK.
    tv_d = (state_d == APPLY || state_d == CHECK) ? idx_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      tv_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      tv_q     <= tv_d;
    end
  end

  sweep_mismatch_logger #(
    .VW   (VW),
    .ERRW (ERRW)
  ) u_logger (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .check_en       (check_en),
    .mismatch       (mismatch),
    .idx            (idx_q),
    .err_count      (errCount),
    .first_fail_vec (firstFailVec),
    .first_fail_vld (firstFailVld)
  );

  assign bus.tvA   = tv_q[VW-1:WIDTH+1];
  assign bus.tvB   = tv_q[WIDTH:1];
  assign bus.tvCin = tv_q[0];

  assign busy = (state_q == APPLY) || (state_q == CHECK);
  assign done = (state_q == DONE);
  assign pass = done && (errCount == '0);

endmodule

// File: tb/tb_adder_sweep_controller.sv
// Scoreboard bench: three controller variants (default, stop-on-fail, 3-bit counter)
// sweep a bench-side adder with injectable faults; a monitor checks each sweep result.
module tb_adder_sweep_controller;

  typedef struct {
    logic [31:0] err;
    logic [31:0] ffv;
    logic [31:0] vld;
    logic [31:0] pass;
    logic [31:0] cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] mask;
  logic        stuck;
  int unsigned cyc = 0;
  int unsigned s_edge = 0;
  bit          mon_en = 1'b0;
  int unsigned total = 0;
  int unsigned bad = 0;

  exp_t sbq [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_sweep_controller_if #(.WIDTH(2)) if0 ();
  adder_sweep_controller_if #(.WIDTH(2)) if1 ();
  adder_sweep_controller_if #(.WIDTH(2)) if2 ();

  logic [2:0] busy_v, done_v, pass_v, vld_v;
  logic [7:0] err0, err1;
  logic [2:0] err2;
  logic [4:0] ffv0, ffv1, ffv2;

  adder_sweep_controller #(.WIDTH(2), .SETTLE(2), .ERRW(8), .STOP_ON_FAIL(1'b0)) u0 (
    .clk(clk), .reset(rst), .start(start), .bus(if0),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .errCount(err0), .firstFailVec(ffv0), .firstFailVld(vld_v[0]));

  adder_sweep_controller #(.WIDTH(2), .SETTLE(2), .ERRW(8), .STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .reset(rst), .start(start), .bus(if1),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .errCount(err1), .firstFailVec(ffv1), .firstFailVld(vld_v[1]));

  adder_sweep_controller #(.WIDTH(2), .SETTLE(2), .ERRW(3), .STOP_ON_FAIL(1'b0)) u2 (
    .clk(clk), .reset(rst), .start(start), .bus(if2),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .errCount(err2), .firstFailVec(ffv2), .firstFailVld(vld_v[2]));

  // Golden = true A+B+Cin; DUT flips carry on masked vectors and optionally forces sum to 00.
  function automatic logic [5:0] adders(input logic [1:0] a, input logic [1:0] b,
                                        input logic c, input logic [31:0] m, input logic st);
    logic [2:0] g;
    logic [2:0] d;
    logic [4:0] v;
    g = {1'b0, a} + {1'b0, b} + {2'b00, c};
    d = g;
    v = {a, b, c};
    if (m[v]) d[2] = ~d[2];
    if (st) d[1:0] = 2'b00;
    return {d, g};
  endfunction

  assign {if0.dutCout, if0.dutSum, if0.goldCout, if0.goldSum} = adders(if0.tvA, if0.tvB, if0.tvCin, mask, stuck);
  assign {if1.dutCout, if1.dutSum, if1.goldCout, if1.goldSum} = adders(if1.tvA, if1.tvB, if1.tvCin, mask, stuck);
  assign {if2.dutCout, if2.dutSum, if2.goldCout, if2.goldSum} = adders(if2.tvA, if2.tvB, if2.tvCin, mask, stuck);

  logic [31:0] err_w [3];
  logic [31:0] ffv_w [3];
  logic [31:0] tv_w  [3];
  always_comb begin
    err_w[0] = {24'd0, err0};
    err_w[1] = {24'd0, err1};
    err_w[2] = {29'd0, err2};
    ffv_w[0] = {27'd0, ffv0};
    ffv_w[1] = {27'd0, ffv1};
    ffv_w[2] = {27'd0, ffv2};
    tv_w[0]  = {27'd0, if0.tvA, if0.tvB, if0.tvCin};
    tv_w[1]  = {27'd0, if1.tvA, if1.tvB, if1.tvCin};
    tv_w[2]  = {27'd0, if2.tvA, if2.tvB, if2.tvCin};
  end

  task automatic chk(input string name, input int unsigned k, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[u%0d] got=%0d want=%0d at t=%0t", name, k, act, exp, $time);
    end
  endtask

  // Reference: walk all 32 vectors with plain arithmetic, honouring stop and saturation.
  function automatic exp_t model(input bit stop, input int unsigned emax,
                                 input logic [31:0] m, input bit st);
    exp_t e;
    int unsigned cnt = 0;
    int unsigned last = 31;
    bit found = 0;
    e.ffv = 0;
    for (int unsigned v = 0; v < 32; v++) begin
      int unsigned a = (v >> 3) & 3;
      int unsigned b = (v >> 1) & 3;
      int unsigned c = v & 1;
      bit mm = (m[v] == 1'b1) || (st && ((a + b + c) % 4 != 0));
      if (mm) begin
        cnt++;
        if (!found) begin
          found = 1;
          e.ffv = v;
        end
        if (stop) begin
          last = v;
          break;
        end
      end
    end
    e.err    = (cnt > emax) ? emax : cnt;
    e.vld    = found ? 1 : 0;
    e.pass   = (cnt == 0) ? 1 : 0;
    e.cycles = (last + 1) * 3;
    return e;
  endfunction

  logic [2:0] busy_p = '0;
  logic [2:0] done_p = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (busy_v[k]) chk("tv_seq", k, tv_w[k], (cyc - s_edge) / 3);
        else           chk("tv_idle", k, tv_w[k], 0);
        if (busy_v[k] && !busy_p[k]) begin
          chk("clr_err", k, err_w[k], 0);
          chk("clr_vld", k, {31'd0, vld_v[k]}, 0);
        end
        if (done_v[k] && !done_p[k]) begin
          if (sbq[k].size() == 0) begin
            chk("unexp_done", k, 1, 0);
          end else begin
            exp_t e;
            e = sbq[k].pop_front();
            chk("errCount", k, err_w[k], e.err);
            chk("ffVec", k, ffv_w[k], e.ffv);
            chk("ffVld", k, {31'd0, vld_v[k]}, e.vld);
            chk("pass", k, {31'd0, pass_v[k]}, e.pass);
            chk("latency", k, cyc - s_edge, e.cycles);
          end
        end
      end
    end
    busy_p <= busy_v;
    done_p <= done_v;
  end

  task automatic run(input logic [31:0] m, input bit st, input bit pokes);
    int unsigned n = 0;
    mask  = m;
    stuck = st;
    sbq[0].push_back(model(0, 255, m, st));
    sbq[1].push_back(model(1, 255, m, st));
    sbq[2].push_back(model(0, 7, m, st));
    s_edge = cyc + 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (pokes) begin
      for (int i = 0; i < 5; i++) begin
        repeat ($urandom_range(5, 15)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    while (done_v != 3'b111 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_v != 3'b111) chk("timeout", 0, {29'd0, done_v}, 7);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mask  = '0;
    stuck = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", k, {31'd0, busy_v[k]}, 0);
      chk("rst_done", k, {31'd0, done_v[k]}, 0);
      chk("rst_pass", k, {31'd0, pass_v[k]}, 0);
      chk("rst_err", k, err_w[k], 0);
      chk("rst_vld", k, {31'd0, vld_v[k]}, 0);
      chk("rst_tv", k, tv_w[k], 0);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    run(32'h0, 1'b0, 1'b1);
    run(32'h0080_0000, 1'b0, 1'b0);
    run(32'h0, 1'b1, 1'b0);
    run(32'hFFFF_FFFF, 1'b0, 1'b0);

    // Abort a sweep with reset; no result is expected from it.
    mask = '0;
    stuck = 1'b0;
    s_edge = cyc + 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rstmid_busy", k, {31'd0, busy_v[k]}, 0);
      chk("rstmid_tv", k, tv_w[k], 0);
      chk("rstmid_err", k, err_w[k], 0);
    end
    rst = 1'b0;
    @(negedge clk);
    run(32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] m;
      m = $urandom() & $urandom() & $urandom();
      run(m, ($urandom_range(0, 3) == 0), 1'b0);
    end

    for (int k = 0; k < 3; k++) chk("sb_empty", k, sbq[k].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
